// File: rtl/cla_slice_sequencer_if.sv
// Operand/result handshake bundle for cla_slice_sequencer.
// Optional macro CLA_SEQ_ADD_SUB_EN adds the 'op' (0 = add, 1 = subtract) signal.
interface cla_slice_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;
`ifdef CLA_SEQ_ADD_SUB_EN
  logic             op;

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, busy
  );
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, busy
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, busy
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, busy
  );
`endif
endinterface

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit CLA slice reused per nibble, carry chained in a register.
// Optional macro CLA_SEQ_ADD_SUB_EN enables subtraction (a + ~b + 1) selected by bus.op.
module cla_slice_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_slice_sequencer_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("cla_slice_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [3:0] nib_a, nib_b, p, g, s;
  logic [4:0] c;

  always_comb begin
    nib_a = a_q[4*int'(idx_q) +: 4];
    nib_b = b_q[4*int'(idx_q) +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s     = p ^ c[3:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d = bus.a;
`ifdef CLA_SEQ_ADD_SUB_EN
          // Subtract stores ~b and seeds the carry with 1; cin is ignored.
          b_d     = bus.op ? ~bus.b : bus.b;
          carry_d = bus.op ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[4*int'(idx_q) +: 4] = s;
        carry_d = c[4];
        if (idx_q == LastIdx) begin
          sum_d[WIDTH] = c[4];
          idx_d        = '0;
          state_d      = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;

endmodule
